// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, multicycle-EX and memory-wait freezes,
// branch flush, and a saturating count of cycles where the PC was held.
module hazard_ctrl_unit #(
    parameter int REG_AW          = 5,
    parameter int LU_BUBBLES      = 1,
    parameter int MDU_LATENCY     = 4,
    parameter int ZERO_REG_FILTER = 1,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead_IDEX,
    input  logic [REG_AW-1:0] rd_IDEX,
    input  logic [REG_AW-1:0] rs1_IFID,
    input  logic [REG_AW-1:0] rs2_IFID,
    input  logic              use_rs1_IFID,
    input  logic              use_rs2_IFID,
    input  logic              PCSrcE,
    input  logic              mdu_start_IDEX,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              Write_IFID,
    output logic              control_mux_sel,
    output logic              lwStall,
    output logic              FlushIFID,
    output logic              FlushIDEX,
    output logic              StallEX,
    output logic              StallMEM,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {IDLE, LU_STALL, MDU_BUSY} state_t;

    localparam logic [4:0] MDU_LOAD = 5'(MDU_LATENCY - 2);
    localparam logic [4:0] LU_LOAD  = 5'(LU_BUBBLES - 1);

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              rd_is_zero;
    logic              lw_raw;

    assign rd_is_zero = (ZERO_REG_FILTER != 0) && (rd_IDEX == '0);
    assign lw_raw = MemRead_IDEX && !rd_is_zero &&
                    ((use_rs1_IFID && (rd_IDEX == rs1_IFID)) ||
                     (use_rs2_IFID && (rd_IDEX == rs2_IFID)));

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        PCWrite         = 1'b1;
        Write_IFID      = 1'b1;
        control_mux_sel = 1'b0;
        FlushIFID       = 1'b0;
        FlushIDEX       = 1'b0;
        StallEX         = 1'b0;
        StallMEM        = 1'b0;
        lwStall         = lw_raw && !rst;
        if (rst) begin
            state_d = IDLE;
        end else if (!mem_ready) begin
            // Whole-pipe freeze: state and count hold, a pending flush waits.
            PCWrite    = 1'b0;
            Write_IFID = 1'b0;
            StallEX    = 1'b1;
            StallMEM   = 1'b1;
        end else if (state_q == MDU_BUSY || (state_q == IDLE && mdu_start_IDEX)) begin
            PCWrite    = 1'b0;
            Write_IFID = 1'b0;
            StallEX    = 1'b1;
            if (state_q == IDLE) begin
                if (MDU_LOAD != 5'd0) begin
                    cnt_d   = MDU_LOAD;
                    state_d = MDU_BUSY;
                end
            end else begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = IDLE;
            end
        end else if (PCSrcE) begin
            FlushIFID = 1'b1;
            FlushIDEX = 1'b1;
            if (state_q == LU_STALL) begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        end else if (state_q == LU_STALL || (state_q == IDLE && lw_raw)) begin
            PCWrite         = 1'b0;
            Write_IFID      = 1'b0;
            control_mux_sel = 1'b1;
            if (state_q == IDLE) begin
                if (LU_LOAD != 5'd0) begin
                    cnt_d   = LU_LOAD;
                    state_d = LU_STALL;
                end
            end else begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = IDLE;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!PCWrite && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 5'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (1 and 3 load-use bubbles) driven in
// lockstep and compared each cycle against a remaining-cycles reference model.
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_read = 1'b0, u1 = 1'b0, u2 = 1'b0, pcsrc = 1'b0, start = 1'b0, ready = 1'b1;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
    logic [7:0] oa, ob;
    logic [2:0] sc_a;
    logic [15:0] sc_b;

    int n_checks = 0;
    int n_err = 0;
    int lu_left[2];
    int mdu_left[2];
    int sc[2];
    int bubbles[2] = '{1, 3};
    int sc_max[2] = '{7, 65535};
    localparam int LAT = 4;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .LU_BUBBLES(1), .MDU_LATENCY(LAT), .ZERO_REG_FILTER(1), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .MemRead_IDEX(mem_read), .rd_IDEX(rd), .rs1_IFID(rs1), .rs2_IFID(rs2),
        .use_rs1_IFID(u1), .use_rs2_IFID(u2), .PCSrcE(pcsrc), .mdu_start_IDEX(start), .mem_ready(ready),
        .PCWrite(oa[7]), .Write_IFID(oa[6]), .control_mux_sel(oa[5]), .lwStall(oa[4]),
        .FlushIFID(oa[3]), .FlushIDEX(oa[2]), .StallEX(oa[1]), .StallMEM(oa[0]), .stall_cycles(sc_a));

    hazard_ctrl_unit #(.REG_AW(5), .LU_BUBBLES(3), .MDU_LATENCY(LAT), .ZERO_REG_FILTER(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .MemRead_IDEX(mem_read), .rd_IDEX(rd), .rs1_IFID(rs1), .rs2_IFID(rs2),
        .use_rs1_IFID(u1), .use_rs2_IFID(u2), .PCSrcE(pcsrc), .mdu_start_IDEX(start), .mem_ready(ready),
        .PCWrite(ob[7]), .Write_IFID(ob[6]), .control_mux_sel(ob[5]), .lwStall(ob[4]),
        .FlushIFID(ob[3]), .FlushIDEX(ob[2]), .StallEX(ob[1]), .StallMEM(ob[0]), .stall_cycles(sc_b));

    // Outputs: {PCWrite, Write_IFID, control_mux_sel, lwStall, FlushIFID, FlushIDEX, StallEX, StallMEM}
    function automatic logic [7:0] model_out(int k);
        logic lw;
        bit idle;
        lw = mem_read && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        idle = (lu_left[k] == 0) && (mdu_left[k] == 0);
        if (rst) return 8'b1100_0000;
        if (!ready) return {3'b000, lw, 4'b0011};
        if (mdu_left[k] > 0 || (idle && start)) return {3'b000, lw, 4'b0010};
        if (pcsrc) return {3'b110, lw, 4'b1100};
        if (lu_left[k] > 0 || (idle && lw)) return {3'b001, lw, 4'b0000};
        return {3'b110, lw, 4'b0000};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            lu_left[k] = 0; mdu_left[k] = 0; sc[k] = 0;
        end
    endtask

    task automatic model_step(int k);
        logic [7:0] o;
        bit idle;
        if (rst) begin
            lu_left[k] = 0; mdu_left[k] = 0; sc[k] = 0;
            return;
        end
        o = model_out(k);
        idle = (lu_left[k] == 0) && (mdu_left[k] == 0);
        if (!o[7] && sc[k] < sc_max[k]) sc[k]++;
        if (!ready) return;
        if (mdu_left[k] > 0) mdu_left[k]--;
        else if (idle && start) mdu_left[k] = LAT - 2;
        else if (pcsrc) lu_left[k] = 0;
        else if (lu_left[k] > 0) lu_left[k]--;
        else if (o[4]) lu_left[k] = bubbles[k] - 1;
    endtask

    task automatic set_in(logic mr, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                          logic a1, logic a2, logic pc, logic st, logic rdy);
        mem_read = mr; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2;
        pcsrc = pc; start = st; ready = rdy;
    endtask

    task automatic idle_in();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        model_clear();
        #4;
        n_checks++;
        if ({oa, ob} !== 16'hC0C0) begin
            n_err++; $display("FAIL reset_outs got=%b exp=%b", {oa, ob}, 16'hC0C0);
        end
        n_checks++;
        if (sc_a !== 3'd0 || sc_b !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", sc_a, sc_b);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle_in();
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) set_in(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            else idle_in();
            #4;
            n_checks++;
            if ({oa, ob} !== {model_out(0), model_out(1)}) begin
                n_err++; $display("FAIL load_use cyc=%0d got=%b exp=%b", i, {oa, ob}, {model_out(0), model_out(1)});
            end
            n_checks++;
            if (sc_a !== 3'(sc[0]) || sc_b !== 16'(sc[1])) begin
                n_err++; $display("FAIL load_use_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, sc_a, sc_b, sc[0], sc[1]);
            end
            advance();
        end
        #4;
        n_checks++;
        if (sc_a !== 3'd1 || sc_b !== 16'd3) begin
            n_err++; $display("FAIL load_use_total got=%0d/%0d exp=1/3", sc_a, sc_b);
        end
    endtask

    task automatic test_zero_filter();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
                1: set_in(1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                2: set_in(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
                default: set_in(1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            endcase
            #4;
            n_checks++;
            if ({oa, ob} !== {model_out(0), model_out(1)} || oa[4] !== 1'b0) begin
                n_err++; $display("FAIL zero_filter cyc=%0d got=%b exp=%b", i, {oa, ob}, {model_out(0), model_out(1)});
            end
            advance();
        end
        #4;
        n_checks++;
        if (sc_a !== 3'd0 || sc_b !== 16'd0) begin
            n_err++; $display("FAIL zero_filter_cnt got=%0d/%0d exp=0/0", sc_a, sc_b);
        end
    endtask

    task automatic test_mdu_and_freeze(bit with_freeze);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 0) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            else if (with_freeze && (i == 1 || i == 2)) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            else if (with_freeze && i <= 5) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            else idle_in();
            #4;
            n_checks++;
            if ({oa, ob} !== {model_out(0), model_out(1)}) begin
                n_err++; $display("FAIL mdu frz=%0d cyc=%0d got=%b exp=%b", with_freeze, i, {oa, ob}, {model_out(0), model_out(1)});
            end
            n_checks++;
            if (sc_a !== 3'(sc[0]) || sc_b !== 16'(sc[1])) begin
                n_err++; $display("FAIL mdu_cnt frz=%0d cyc=%0d got=%0d/%0d exp=%0d/%0d", with_freeze, i, sc_a, sc_b, sc[0], sc[1]);
            end
            advance();
        end
        #4;
        n_checks++;
        if (sc_b !== (with_freeze ? 16'd5 : 16'd3)) begin
            n_err++; $display("FAIL mdu_total frz=%0d got=%0d exp=%0d", with_freeze, sc_b, with_freeze ? 5 : 3);
        end
    endtask

    task automatic test_lu_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) set_in(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            else if (i == 1) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            else idle_in();
            #4;
            n_checks++;
            if ({oa, ob} !== {model_out(0), model_out(1)}) begin
                n_err++; $display("FAIL lu_flush cyc=%0d got=%b exp=%b", i, {oa, ob}, {model_out(0), model_out(1)});
            end
            advance();
        end
        #4;
        n_checks++;
        if (sc_b !== 16'd1) begin
            n_err++; $display("FAIL lu_flush_cnt got=%0d exp=1", sc_b);
        end
    endtask

    task automatic test_reset_mid_mdu();
        do_reset();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        advance();
        set_in(1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #4;
        n_checks++;
        if (ob[1] !== 1'b1 || sc_b !== 16'd1) begin
            n_err++; $display("FAIL mid_mdu_busy got=%b/%0d exp StallEX=1 cnt=1", ob, sc_b);
        end
        rst = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if ({oa, ob} !== 16'hC0C0 || sc_a !== 3'd0 || sc_b !== 16'd0) begin
            n_err++; $display("FAIL reset_mid_mdu got=%b cnt=%0d/%0d exp=%b cnt=0/0", {oa, ob}, sc_a, sc_b, 16'hC0C0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle_in();
        #4;
        n_checks++;
        if ({oa, ob} !== {model_out(0), model_out(1)}) begin
            n_err++; $display("FAIL after_reset_mid got=%b exp=%b", {oa, ob}, {model_out(0), model_out(1)});
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) != 0));
            #4;
            n_checks++;
            if ({oa, ob} !== {model_out(0), model_out(1)}) begin
                n_err++; $display("FAIL random cyc=%0d got=%b exp=%b", i, {oa, ob}, {model_out(0), model_out(1)});
            end
            n_checks++;
            if (sc_a !== 3'(sc[0]) || sc_b !== 16'(sc[1])) begin
                n_err++; $display("FAIL random_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, sc_a, sc_b, sc[0], sc[1]);
            end
            advance();
        end
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_zero_filter();
        test_mdu_and_freeze(1'b0);
        test_mdu_and_freeze(1'b1);
        test_lu_flush();
        test_reset_mid_mdu();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
